// File: rtl/dvp_stream_src.sv
// DVP camera source: registers vsync/href/data, pairs bytes into RGB565 pixels, skips start-up frames.
// Optional frame checker enabled by defining DVP_FRAME_CHK_EN; otherwise frame_err is tied low.
module dvp_stream_src #(
  parameter int H_PIX       = 640,
  parameter int V_LINES     = 480,
  parameter int SKIP_FRAMES = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cap_en,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic        dout_sop,
  output logic        dout_eop,
  output logic        dout_vld,
  output logic [15:0] dout,
  output logic        frame_err
);
  localparam int CW = $clog2(H_PIX + 1);
  localparam int RW = $clog2(V_LINES + 1);
  localparam int SW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
  localparam logic [CW-1:0] COL_END  = CW'(H_PIX);
  localparam logic [CW-1:0] COL_LAST = CW'(H_PIX - 1);
  localparam logic [RW-1:0] ROW_END  = RW'(V_LINES);
  localparam logic [RW-1:0] ROW_LAST = RW'(V_LINES - 1);

  typedef enum logic [1:0] {IDLE, SKIP, ARMED, ACTIVE} state_t;
  state_t state;

  logic          v_r, v_d, h_r, h_d;
  logic [7:0]    d_r, hi;
  logic          phase, cap_l;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [SW-1:0] skip_cnt;
  logic          v_rise, v_fall, pix_en, pix_ok, last_skip, at_last;

  assign v_rise    = v_r & ~v_d;
  assign v_fall    = ~v_r & v_d;
  assign pix_en    = (state == ACTIVE) && h_r && !v_r && phase;
  // col/row park at their END value once past the frame, so "not END" means in range
  assign pix_ok    = (col != COL_END) && (row != ROW_END);
  assign at_last   = (row == ROW_LAST) && (col == COL_LAST);
  assign last_skip = (32'(skip_cnt) == SKIP_FRAMES - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_r <= 1'b0;
      v_d <= 1'b0;
      h_r <= 1'b0;
      h_d <= 1'b0;
      d_r <= '0;
    end else begin
      v_r <= cam_vsync;
      v_d <= v_r;
      h_r <= cam_href;
      h_d <= h_r;
      d_r <= cam_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      skip_cnt <= '0;
      cap_l    <= 1'b0;
      phase    <= 1'b0;
      hi       <= '0;
      col      <= '0;
      row      <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
      dout_sop <= 1'b0;
      dout_eop <= 1'b0;
    end else begin
      dout_vld <= 1'b0;
      dout_sop <= 1'b0;
      dout_eop <= 1'b0;

      case (state)
        IDLE:
          if (v_rise) begin
            cap_l    <= cap_en;
            skip_cnt <= '0;
            state    <= (SKIP_FRAMES == 0) ? ARMED : SKIP;
          end
        SKIP:
          if (v_rise) begin
            cap_l    <= cap_en;
            skip_cnt <= skip_cnt + 1'b1;
            if (last_skip) state <= ARMED;
          end
        ARMED:
          if (v_rise) cap_l <= cap_en;
          else if (v_fall && cap_l) state <= ACTIVE;
        ACTIVE:
          if (v_rise) begin
            cap_l <= cap_en;
            state <= ARMED;
          end
        default: state <= IDLE;
      endcase

      if (!h_r || v_r) phase <= 1'b0;

      if (v_fall) begin
        col <= '0;
        row <= '0;
      end else if (state == ACTIVE && !v_r) begin
        if (h_r) begin
          phase <= ~phase;
          if (!phase) hi <= d_r;
          if (pix_en && pix_ok) begin
            dout     <= {hi, d_r};
            dout_vld <= 1'b1;
            dout_sop <= (row == '0) && (col == '0);
            dout_eop <= at_last;
            col      <= col + 1'b1;
          end
        end else if (h_d && col != '0) begin
          col <= '0;
          if (row != ROW_END) row <= row + 1'b1;
        end
      end
    end
  end

`ifdef DVP_FRAME_CHK_EN
  logic eop_seen, err_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      eop_seen  <= 1'b0;
      err_done  <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (v_fall) begin
        eop_seen <= 1'b0;
        err_done <= 1'b0;
      end else if (state == ACTIVE) begin
        if (v_rise) begin
          if (!eop_seen && !err_done) frame_err <= 1'b1;
          err_done <= 1'b1;
        end else if (pix_en && !pix_ok && !err_done) begin
          frame_err <= 1'b1;
          err_done  <= 1'b1;
        end
        if (pix_en && pix_ok && at_last) eop_seen <= 1'b1;
      end
    end
  end
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_dvp_stream_src.sv
// Bench for dvp_stream_src: frame-level model schedules expected beats/errors by clock edge,
// a per-cycle monitor compares, and literal checks pin key pixel values.
module tb_dvp_stream_src;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int SK = 2;
`ifdef DVP_FRAME_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, cap_en, cam_vsync, cam_href;
  logic [7:0]  cam_data;
  logic        dout_sop, dout_eop, dout_vld, frame_err;
  logic [15:0] dout;

  dvp_stream_src #(.H_PIX(H), .V_LINES(V), .SKIP_FRAMES(SK)) dut (
    .clk(clk), .rst_n(rst_n), .cap_en(cap_en), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .dout_sop(dout_sop), .dout_eop(dout_eop), .dout_vld(dout_vld),
    .dout(dout), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] px; bit sop; bit eop; } beat_t;
  beat_t       exp_beat [int];
  bit          exp_err  [int];
  logic [15:0] obs_px [$];
  bit          obs_sop [$];
  bit          obs_eop [$];
  int          obs_err = 0;
  int          tests = 0, fails = 0;
  int          edge_n = 0;
  bit          mon_on = 0;
  bit          ev;
  int          rises = 0;
  bit          prev_stream = 0, prev_eop = 0, prev_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, req, edge_n);
    end
  endtask

  // Outputs after edge N are compared against what the model scheduled for edge N.
  always @(negedge clk) begin
    if (mon_on) begin
      ev = exp_beat.exists(edge_n);
      chk("vld", dout_vld, ev);
      chk("sop", dout_sop, ev ? exp_beat[edge_n].sop : 1'b0);
      chk("eop", dout_eop, ev ? exp_beat[edge_n].eop : 1'b0);
      if (ev) chk("dout", dout, exp_beat[edge_n].px);
      chk("frame_err", frame_err, CHK && exp_err.exists(edge_n));
      if (dout_vld) begin
        obs_px.push_back(dout);
        obs_sop.push_back(dout_sop);
        obs_eop.push_back(dout_eop);
      end
      if (frame_err) obs_err++;
    end
  end

  task automatic drive(input bit v, input bit h, input logic [7:0] d);
    cam_vsync = v;
    cam_href  = h;
    cam_data  = d;
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic clear_obs();
    obs_px.delete();
    obs_sop.delete();
    obs_eop.delete();
    obs_err = 0;
  endtask

  // One frame: vsync pulse, blanking, nl lines of nb0/nb1 bytes valued 0,1,2.. from frame start.
  task automatic send_frame(input int nl, input int nb0, input int nb1,
                            input bit cap_r, input bit cap_m, input bit rst_mid);
    int         row, nb, col;
    logic [7:0] bv, hi;
    bit         strm, eop_s, err_s;
    row = 0; bv = 8'h00; hi = 8'h00; eop_s = 0; err_s = 0;
    cap_en = cap_r;
    drive(1, 0, 8'h00);
    rises++;
    if (prev_stream && !prev_eop && !prev_err) exp_err[edge_n + 1] = 1'b1;
    drive(1, 0, 8'h00);
    drive(1, 0, 8'h00);
    strm   = (rises > SK) && cap_r;
    cap_en = cap_m;
    repeat (3) drive(0, 0, 8'h00);
    for (int l = 0; l < nl; l++) begin
      nb = (l == 0) ? nb0 : nb1;
      for (int i = 0; i < nb; i++) begin
        drive(0, 1, bv);
        if (i % 2 == 0) hi = bv;
        else if (strm) begin
          col = i / 2;
          if (col < H && row < V) begin
            exp_beat[edge_n + 1] = '{px: {hi, bv}, sop: (row == 0 && col == 0),
                                     eop: (row == V - 1 && col == H - 1)};
            if (row == V - 1 && col == H - 1) eop_s = 1;
          end else if (!err_s) begin
            exp_err[edge_n + 1] = 1'b1;
            err_s = 1;
          end
        end
        bv++;
      end
      drive(0, 0, 8'h00);
      drive(0, 0, 8'h00);
      if (nb >= 2 && row < V) row++;
      if (rst_mid && l == 0) begin
        chk("held_dout_pre_rst", dout, 16'h0607);
        rst_n = 1'b0;
        #1;
        chk("rst_now_dout", dout, 16'h0000);
        chk("rst_now_vld", dout_vld, 1'b0);
        chk("rst_now_err", frame_err, 1'b0);
        @(posedge clk);
        edge_n++;
        #1;
        rst_n = 1'b1;
        rises = 0;
        strm  = 0;
      end
    end
    prev_stream = strm;
    prev_eop    = eop_s;
    prev_err    = err_s;
  endtask

  int n_eop;

  initial begin
    rst_n = 1'b0; cap_en = 1'b1; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'h00;
    repeat (2) drive(0, 0, 8'h00);
    chk("reset_dout", dout, 16'h0000);
    chk("reset_vld", dout_vld, 1'b0);
    chk("reset_sop", dout_sop, 1'b0);
    chk("reset_eop", dout_eop, 1'b0);
    chk("reset_err", frame_err, 1'b0);
    rst_n  = 1'b1;
    mon_on = 1;
    repeat (3) drive(0, 0, 8'h00);

    // start-up skip then first streamed frame
    send_frame(2, 8, 8, 1, 1, 0);
    send_frame(2, 8, 8, 1, 1, 0);
    chk("t1_skipped_beats", obs_px.size(), 0);
    send_frame(2, 8, 8, 1, 1, 0);
    chk("t1_beats", obs_px.size(), 8);
    if (obs_px.size() == 8) begin
      chk("t1_first_px", obs_px[0], 16'h0001);
      chk("t1_first_sop", obs_sop[0], 1'b1);
      chk("t1_last_px", obs_px[7], 16'h0e0f);
      chk("t1_last_eop", obs_eop[7], 1'b1);
    end
    clear_obs();

    // cap_en low at vsync rise, raised mid-frame
    send_frame(2, 8, 8, 0, 1, 0);
    chk("t2_suppressed", obs_px.size(), 0);
    send_frame(2, 8, 8, 1, 1, 0);
    chk("t2_next_beats", obs_px.size(), 8);
    clear_obs();

    // odd-length line
    send_frame(2, 9, 8, 1, 1, 0);
    chk("t3_beats", obs_px.size(), 8);
    if (obs_px.size() == 8) chk("t3_line1_px0", obs_px[4], 16'h090a);
    chk("t3_no_err", obs_err, 0);
    clear_obs();

    // over-long line
    send_frame(2, 10, 8, 1, 1, 0);
    chk("t4_beats", obs_px.size(), 8);
    if (obs_px.size() == 8) chk("t4_line1_px0", obs_px[4], 16'h0a0b);
    chk("t4_err_pulses", obs_err, CHK ? 1 : 0);
    clear_obs();

    // short frame, then a normal one
    send_frame(1, 8, 0, 1, 1, 0);
    chk("t5_beats", obs_px.size(), 4);
    n_eop = 0;
    foreach (obs_eop[i]) n_eop += obs_eop[i];
    chk("t5_no_eop", n_eop, 0);
    if (obs_px.size() > 0) chk("t5_sop", obs_sop[0], 1'b1);
    clear_obs();
    send_frame(2, 8, 8, 1, 1, 0);
    chk("t5_err_at_rise", obs_err, CHK ? 1 : 0);
    chk("t5_next_beats", obs_px.size(), 8);
    if (obs_px.size() > 0) chk("t5_next_sop", obs_sop[0], 1'b1);
    clear_obs();

    // async reset mid-frame, skip re-applied
    send_frame(2, 8, 8, 1, 1, 1);
    chk("t6_pre_rst_beats", obs_px.size(), 4);
    clear_obs();
    send_frame(2, 8, 8, 1, 1, 0);
    send_frame(2, 8, 8, 1, 1, 0);
    chk("t6_skipped_beats", obs_px.size(), 0);
    send_frame(2, 8, 8, 1, 1, 0);
    chk("t6_resumed_beats", obs_px.size(), 8);
    if (obs_px.size() == 8) chk("t6_resumed_eop", obs_eop[7], 1'b1);

    drive(1, 0, 8'h00);
    rises++;
    if (prev_stream && !prev_eop && !prev_err) exp_err[edge_n + 1] = 1'b1;
    repeat (4) drive(1, 0, 8'h00);
    repeat (3) drive(0, 0, 8'h00);
    mon_on = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
